// File: rtl/stepper_pkg.sv
// Shared types and coil pattern tables for the stepper ramp controller.
// The pattern lookup is shared by the phase generator and anything decoding the index.
package stepper_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Half-step: 8 phases alternating one and two coils on. Full-step: idx[2:1], two coils on.
    function automatic logic [3:0] coil_pattern(input logic [2:0] idx, input logic half);
        logic [3:0] pat;
        pat = 4'b0000;
        if (half) begin
            case (idx)
                3'd0: pat = 4'b1000;
                3'd1: pat = 4'b1100;
                3'd2: pat = 4'b0100;
                3'd3: pat = 4'b0110;
                3'd4: pat = 4'b0010;
                3'd5: pat = 4'b0011;
                3'd6: pat = 4'b0001;
                default: pat = 4'b1001;
            endcase
        end else begin
            case (idx[2:1])
                2'd0: pat = 4'b1100;
                2'd1: pat = 4'b0110;
                2'd2: pat = 4'b0011;
                default: pat = 4'b1001;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// 3-bit phase index with mod-8 wrap; advances by 1 (half) or 2 (full) per step.
// Produces the coil pattern for the current index and mode.
module stepper_phase_gen
    import stepper_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       half_i,
    input  logic       clr_bit0_i,
    output logic [3:0] pattern_o
);

    logic [2:0] idx_q, idx_d;
    logic [2:0] inc;

    always_comb begin
        inc   = half_i ? 3'd1 : 3'd2;
        idx_d = idx_q;
        if (clr_bit0_i) begin
            idx_d = {idx_q[2:1], 1'b0};
        end else if (step_i) begin
            idx_d = dir_i ? idx_q + inc : idx_q - inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign pattern_o = coil_pattern(idx_q, half_i);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Single-axis stepper controller: accepts a move command and issues steps with a
// trapezoidal period ramp between START_TICKS and MIN_TICKS, tracking signed position.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 125_000_000,
    parameter int unsigned STEP_W      = 16,
    parameter int unsigned POS_W       = 24,
    parameter int unsigned TICK_W      = 24,
    parameter int unsigned START_TICKS = 416_666,
    parameter int unsigned MIN_TICKS   = 125_000,
    parameter int unsigned DELTA_TICKS = 2_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic              cmd_half,
    input  logic              abort,
    input  logic              hold_en,
    output logic [3:0]        coils,
    output logic              step_strobe,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    if (MIN_TICKS > START_TICKS || CLK_HZ == 0) begin : g_param_check
        $error("stepper_ramp_ctrl: MIN_TICKS must not exceed START_TICKS");
    end

    localparam logic [TICK_W-1:0] StartT = TICK_W'(START_TICKS);
    localparam logic [TICK_W-1:0] MinT   = TICK_W'(MIN_TICKS);
    localparam logic [TICK_W-1:0] DeltaT = TICK_W'(DELTA_TICKS);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] period_q, period_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [STEP_W-1:0] rs_q, rs_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    logic              accept;
    logic              step;
    logic              clr_bit0;
    logic [STEP_W-1:0] rem_after;
    logic [POS_W-1:0]  step_mag;
    logic [3:0]        pattern;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        rs_d      = rs_q;
        dir_d     = dir_q;
        half_d    = half_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        pos_d     = pos_q;
        step      = 1'b0;
        clr_bit0  = 1'b0;
        accept    = cmd_valid && (state_q == StIdle);
        rem_after = rem_q - 1'b1;
        step_mag  = half_q ? POS_W'(1) : POS_W'(2);

        case (state_q)
            StIdle: begin
                if (accept) begin
                    dir_d    = cmd_dir;
                    half_d   = cmd_half;
                    clr_bit0 = !cmd_half;
                    period_d = StartT;
                    cnt_d    = TICK_W'(1);
                    rs_d     = '0;
                    rem_d    = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Abort wins over a step that falls due on the same edge.
                if (abort || rem_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (cnt_q >= period_q) begin
                    step     = 1'b1;
                    strobe_d = 1'b1;
                    cnt_d    = TICK_W'(1);
                    rem_d    = rem_after;
                    pos_d    = dir_q ? pos_q + step_mag : pos_q - step_mag;
                    if (rem_after <= rs_q) begin
                        period_d = (StartT - period_q <= DeltaT) ? StartT : period_q + DeltaT;
                        rs_d     = (rs_q == '0) ? '0 : rs_q - 1'b1;
                    end else if (period_q > MinT) begin
                        period_d = (period_q - MinT <= DeltaT) ? MinT : period_q - DeltaT;
                        rs_d     = rs_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            period_q <= StartT;
            cnt_q    <= '0;
            rem_q    <= '0;
            rs_q     <= '0;
            dir_q    <= 1'b0;
            half_q   <= 1'b1;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            rs_q     <= rs_d;
            dir_q    <= dir_d;
            half_q   <= half_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            pos_q    <= pos_d;
        end
    end

    stepper_phase_gen u_phase_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .step_i     (step),
        .dir_i      (dir_q),
        .half_i     (half_q),
        .clr_bit0_i (clr_bit0),
        .pattern_o  (pattern)
    );

    assign busy        = (state_q == StRun);
    assign cmd_ready   = (state_q == StIdle);
    assign coils       = (busy || hold_en) ? pattern : 4'b0000;
    assign step_strobe = strobe_q;
    assign done        = done_q;
    assign position    = pos_q;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: a schedule-based model (precomputed step gaps) checked every
// cycle, directed scenarios with literal expectations, then randomized moves.
module tb_stepper_ramp_ctrl;

    localparam int ST = 10;
    localparam int MN = 4;
    localparam int DL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic        cmd_half = 1'b0;
    logic        abort = 1'b0;
    logic        hold_en = 1'b0;

    logic        cmd_ready, step_strobe, busy, done;
    logic [3:0]  coils;
    logic [23:0] position;
    logic        cmd_ready4, step_strobe4, busy4, done4;
    logic [3:0]  coils4;
    logic [3:0]  position4;

    always #5 clk = ~clk;

    stepper_ramp_ctrl #(
        .STEP_W(16), .POS_W(24), .TICK_W(24),
        .START_TICKS(ST), .MIN_TICKS(MN), .DELTA_TICKS(DL)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .abort(abort),
        .hold_en(hold_en), .coils(coils), .step_strobe(step_strobe), .busy(busy),
        .done(done), .position(position)
    );

    stepper_ramp_ctrl #(
        .STEP_W(16), .POS_W(4), .TICK_W(24),
        .START_TICKS(ST), .MIN_TICKS(MN), .DELTA_TICKS(DL)
    ) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .abort(abort),
        .hold_en(hold_en), .coils(coils4), .step_strobe(step_strobe4), .busy(busy4),
        .done(done4), .position(position4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] half_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    logic [3:0] full_tab [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    bit m_busy = 0, m_done = 0, m_strobe = 0, m_dir = 0, m_half = 1;
    int m_idx = 0, m_pos = 0, m_left = 0, m_due = 0;
    int gq[$];
    int bq[$];

    // Gap before step k+1 for an n-step move, straight from the ramp rules.
    function automatic void build_gaps(input int n);
        int period, rs, rem;
        bq.delete();
        period = ST;
        rs     = 0;
        bq.push_back(ST);
        for (int k = 1; k < n; k++) begin
            rem = n - k;
            if (rem <= rs) begin
                period = (period + DL > ST) ? ST : period + DL;
                rs     = (rs > 0) ? rs - 1 : 0;
            end else if (period > MN) begin
                period = (period - DL < MN) ? MN : period - DL;
                rs     = rs + 1;
            end
            bq.push_back(period);
        end
    endfunction

    function automatic logic [3:0] m_coils();
        logic [2:0] i;
        i = 3'(m_idx);
        if (!(m_busy || hold_en)) return 4'b0000;
        return m_half ? half_tab[i] : full_tab[i[2:1]];
    endfunction

    always @(posedge clk) begin
        int s;
        cyc++;
        m_strobe = 0;
        m_done   = 0;
        if (rst) begin
            m_busy = 0; m_idx = 0; m_pos = 0; m_half = 1; m_dir = 0; m_left = 0;
            gq.delete();
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_dir  = cmd_dir;
                m_half = cmd_half;
                if (!cmd_half) m_idx = m_idx & 6;
                if (cmd_steps == 0) begin
                    m_done = 1;
                end else begin
                    m_busy = 1;
                    build_gaps(int'(cmd_steps));
                    gq     = bq;
                    m_left = int'(cmd_steps);
                    m_due  = cyc + gq.pop_front();
                end
            end
        end else if (abort || m_left == 0) begin
            m_busy = 0;
            m_done = 1;
        end else if (cyc == m_due) begin
            s        = m_half ? 1 : 2;
            m_strobe = 1;
            m_idx    = (m_idx + (m_dir ? s : -s)) & 7;
            m_pos    = m_pos + (m_dir ? s : -s);
            m_left--;
            if (m_left > 0) m_due = cyc + gq.pop_front();
        end
    end

    // ---------------- per-cycle compare and strobe monitor ----------------
    int sq[$];
    logic [3:0] cq[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("step_strobe", {31'b0, step_strobe}, {31'b0, m_strobe});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !m_busy});
            chk("coils", {28'b0, coils}, {28'b0, m_coils()});
            chk("position", {8'b0, position}, {8'b0, m_pos[23:0]});
            chk("position_w4", {28'b0, position4}, {28'b0, m_pos[3:0]});
            if (step_strobe) begin
                sq.push_back(cyc);
                cq.push_back(coils);
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    int last_acc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit dir, input bit half);
        cmd_steps = 16'(n);
        cmd_dir   = dir;
        cmd_half  = half;
        cmd_valid = 1'b1;
        tick();
        last_acc  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            if (!busy) return;
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: busy still 1 after 3000 cycles, required 0");
    endtask

    task automatic clear_mon();
        sq.delete();
        cq.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_gaps(input string name, input int exp[$]);
        chk({name, "_count"}, 32'(sq.size()), 32'(exp.size()));
        if (sq.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) begin
                chk(name, 32'(sq[i] - ((i == 0) ? last_acc : sq[i-1])), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g8[$];
        int g3[$];
        int g8m[$];
        logic [3:0] c8[$];
        logic [3:0] c3[$];
        int nstr;
        bit seen;

        g8  = '{10, 8, 6, 4, 4, 6, 8, 10};
        g3  = '{10, 8, 10};
        c8  = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
        c3  = '{4'b1001, 4'b0011, 4'b0110};

        // Pin the model's ramp arithmetic against hand-derived gaps.
        build_gaps(8);
        g8m = bq;
        for (int i = 0; i < 8; i++) chk("model_gaps8", 32'(g8m[i]), 32'(g8[i]));
        build_gaps(3);
        for (int i = 0; i < 3; i++) chk("model_gaps3", 32'(bq[i]), 32'(g3[i]));

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_coils", {28'b0, coils}, 32'h0);
        chk("rst_position", {8'b0, position}, 32'h0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        tick();

        // Half, forward, 8 steps
        clear_mon();
        send(8, 1'b1, 1'b1);
        wait_idle();
        repeat (3) tick();
        chk_gaps("half8_gap", g8);
        if (cq.size() == 8) for (int i = 0; i < 8; i++) chk("half8_coils", {28'b0, cq[i]}, {28'b0, c8[i]});
        chk("half8_position", {8'b0, position}, 32'd8);
        chk("half8_wrap_w4", {28'b0, position4}, 32'h8);
        chk("half8_done_cnt", 32'(done_cnt), 32'd1);

        // Full, reverse, 3 steps from index 0
        do_reset();
        clear_mon();
        send(3, 1'b0, 1'b0);
        wait_idle();
        repeat (3) tick();
        chk_gaps("full3_gap", g3);
        if (cq.size() == 3) for (int i = 0; i < 3; i++) chk("full3_coils", {28'b0, cq[i]}, {28'b0, c3[i]});
        chk("full3_position", {8'b0, position}, 32'h00FF_FFFA);

        // Zero-length move
        clear_mon();
        send(0, 1'b1, 1'b1);
        chk("zero_done", {31'b0, done}, 32'h1);
        chk("zero_busy", {31'b0, busy}, 32'h0);
        tick();
        chk("zero_done_fall", {31'b0, done}, 32'h0);
        repeat (15) tick();
        chk("zero_strobes", 32'(sq.size()), 32'd0);

        // Abort after the second strobe of a 20-step move
        do_reset();
        clear_mon();
        hold_en = 1'b0;
        send(20, 1'b1, 1'b1);
        nstr = 0;
        for (int k = 0; k < 200 && nstr < 2; k++) begin
            tick();
            if (step_strobe) nstr++;
        end
        chk("abort_seen_two", 32'(nstr), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", {31'b0, done}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_position", {8'b0, position}, 32'd2);
        chk("abort_coils_off", {28'b0, coils}, 32'h0);
        hold_en = 1'b1;
        #1;
        chk("abort_coils_hold", {28'b0, coils}, 32'h4);
        repeat (30) tick();
        chk("abort_no_third", 32'(sq.size()), 32'd2);

        // Command held valid while busy is accepted on the first idle cycle
        cmd_steps = 16'd5;
        cmd_dir   = 1'b1;
        cmd_half  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_steps = 16'd3;
        cmd_dir   = 1'b0;
        tick();
        chk("held_ready_low", {31'b0, cmd_ready}, 32'h0);
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        chk("held_first_idle", {31'b0, seen}, 32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("held_second_accept", {31'b0, busy}, 32'h1);
        wait_idle();
        tick();

        // Randomized moves with occasional abort, reset and idle aborts
        for (int it = 0; it < 40; it++) begin
            hold_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            send($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 7))
                0, 1: begin
                    for (int k = $urandom_range(1, 40); k > 0 && busy; k--) tick();
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end
                2: begin
                    for (int k = $urandom_range(1, 40); k > 0 && busy; k--) tick();
                    do_reset();
                end
                default: ;
            endcase
            wait_idle();
            tick();
        end

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
